// File: rtl/cpu_mem_sequencer_if.sv
// Purpose : RAM-side bus between cpu_mem_sequencer and a single-port
//           synchronous RAM (1-cycle read latency, byte enables).
// Signals : mem_en    access strobe
//           mem_we    byte write enables, 0 = read
//           mem_addr  word address
//           mem_wdata write data
//           mem_rdata read data, valid the cycle after a read strobe
interface cpu_mem_sequencer_if #(
    parameter int MEM_AW = 10
);
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/cpu_mem_sequencer.sv
// Purpose : Multi-cycle sequencer between a single-cycle core and one
//           single-port RAM. It fetches an instruction, performs that
//           instruction's load or store, and then steps the core with a
//           one-cycle clock enable. While the core is halted, or after a
//           fatal access error, the RAM is shared with a debug/loader port.
// Ports   : clk, reset (sync, active high)
//           halt/halted/err        run control and status
//           cpu_ce/instr/data_in   core step, instruction, load data
//           PC/ALU_result/data_out/MemWrite/SizeLoad/ResultSrc  core request
//           memBus                 RAM port (master side)
//           dbg_*                  debug access port, serviced in HALT/ERR
//
// state | meaning
// FETCH | read instruction at PC (or enter HALT when halt is requested)
// FWAIT | capture instruction from RAM
// EXEC  | core outputs valid: check, then issue load/store or step core
// LWAIT | capture and extend load data
// WB    | step core after a load
// HALT  | core stopped, debug port owns the RAM
// ERR   | sticky fault, debug port still serviced
module cpu_mem_sequencer #(
    parameter int          MEM_AW = 10,
    parameter logic [31:0] NOP    = 32'h0000_0013
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        halt,
    output logic                        halted,
    output logic                        err,
    output logic                        cpu_ce,
    output logic [31:0]                 instr,
    output logic [31:0]                 data_in,
    input  logic [31:0]                 PC,
    input  logic [31:0]                 ALU_result,
    input  logic [31:0]                 data_out,
    input  logic [1:0]                  MemWrite,
    input  logic [2:0]                  SizeLoad,
    input  logic                        ResultSrc,
    cpu_mem_sequencer_if.master         memBus,
    input  logic                        dbg_req,
    input  logic                        dbg_we,
    input  logic [31:0]                 dbg_addr,
    input  logic [31:0]                 dbg_wdata,
    output logic                        dbg_gnt,
    output logic                        dbg_rvalid,
    output logic [31:0]                 dbg_rdata
);
    typedef enum logic [2:0] {FETCH, FWAIT, EXEC, LWAIT, WB, HALT, ERR} state_t;

    state_t      stateQ, stateD;
    logic [1:0]  loadLaneQ;
    logic [2:0]  loadSizeQ;
    logic [31:0] loadExt;
    logic [31:0] byteAddr;

    // A request with both ResultSrc and MemWrite set is a conflict and faults.
    logic isStore, isLoad, misStore, misLoad, badSize, execErr;
    assign isStore  = (MemWrite != 2'b00);
    assign isLoad   = ResultSrc;
    assign misStore = ((MemWrite == 2'b10) && ALU_result[0]) ||
                      ((MemWrite == 2'b11) && (ALU_result[1:0] != 2'b00));
    assign misLoad  = isLoad && !isStore &&
                      (((SizeLoad[1:0] == 2'b01) && ALU_result[0]) ||
                       ((SizeLoad == 3'b010) && (ALU_result[1:0] != 2'b00)));
    assign badSize  = isLoad && !isStore &&
                      ((SizeLoad == 3'b011) || (SizeLoad == 3'b110) || (SizeLoad == 3'b111));
    assign execErr  = misStore || misLoad || badSize || (isLoad && isStore);

    logic dbgSlot;
    assign dbgSlot = ((stateQ == HALT) || (stateQ == ERR)) && dbg_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= halt ? HALT : FETCH;
            instr      <= NOP;
            data_in    <= '0;
            err        <= 1'b0;
            dbg_rvalid <= 1'b0;
            loadLaneQ  <= '0;
            loadSizeQ  <= '0;
        end else begin
            stateQ     <= stateD;
            dbg_rvalid <= dbgSlot && !dbg_we;
            if (stateQ == FWAIT)
                instr <= memBus.mem_rdata;
            if (stateQ == EXEC && execErr)
                err <= 1'b1;
            if (stateQ == EXEC) begin
                loadLaneQ <= ALU_result[1:0];
                loadSizeQ <= SizeLoad;
            end
            if (stateQ == LWAIT)
                data_in <= loadExt;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            FETCH:   stateD = halt ? HALT : FWAIT;
            FWAIT:   stateD = EXEC;
            EXEC:    stateD = execErr ? ERR : (isLoad ? LWAIT : FETCH);
            LWAIT:   stateD = WB;
            WB:      stateD = FETCH;
            HALT:    stateD = (!halt && !dbg_req) ? FETCH : HALT;
            ERR:     stateD = ERR;
            default: stateD = FETCH;
        endcase
    end

    // Strobes are combinational from state and forced low during reset so a
    // pending access is dropped in the reset cycle.
    always_comb begin
        memBus.mem_en    = 1'b0;
        memBus.mem_we    = 4'b0000;
        memBus.mem_wdata = '0;
        byteAddr         = '0;
        cpu_ce           = 1'b0;
        dbg_gnt          = 1'b0;
        if (!reset) begin
            case (stateQ)
                FETCH: if (!halt) begin
                    memBus.mem_en = 1'b1;
                    byteAddr      = PC;
                end
                EXEC: if (!execErr) begin
                    byteAddr = ALU_result;
                    if (isLoad) begin
                        memBus.mem_en = 1'b1;
                    end else begin
                        cpu_ce = 1'b1;
                        if (isStore) begin
                            memBus.mem_en = 1'b1;
                            case (MemWrite)
                                2'b01: begin
                                    memBus.mem_wdata = {4{data_out[7:0]}};
                                    memBus.mem_we    = 4'b0001 << ALU_result[1:0];
                                end
                                2'b10: begin
                                    memBus.mem_wdata = {2{data_out[15:0]}};
                                    memBus.mem_we    = ALU_result[1] ? 4'b1100 : 4'b0011;
                                end
                                default: begin
                                    memBus.mem_wdata = data_out;
                                    memBus.mem_we    = 4'b1111;
                                end
                            endcase
                        end
                    end
                end
                WB: cpu_ce = 1'b1;
                HALT, ERR: if (dbg_req) begin
                    dbg_gnt          = 1'b1;
                    memBus.mem_en    = 1'b1;
                    memBus.mem_we    = dbg_we ? 4'b1111 : 4'b0000;
                    memBus.mem_wdata = dbg_wdata;
                    byteAddr         = dbg_addr;
                end
                default: ;
            endcase
        end
    end

    assign memBus.mem_addr = byteAddr[MEM_AW+1:2];
    assign halted          = !reset && ((stateQ == HALT) || (stateQ == ERR));
    assign dbg_rdata       = dbg_rvalid ? memBus.mem_rdata : 32'h0;

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    always_comb begin
        laneByte = memBus.mem_rdata[8*loadLaneQ +: 8];
        laneHalf = loadLaneQ[1] ? memBus.mem_rdata[31:16] : memBus.mem_rdata[15:0];
        case (loadSizeQ)
            3'b000:  loadExt = {{24{laneByte[7]}}, laneByte};
            3'b001:  loadExt = {{16{laneHalf[15]}}, laneHalf};
            3'b100:  loadExt = {24'h0, laneByte};
            3'b101:  loadExt = {16'h0, laneHalf};
            default: loadExt = memBus.mem_rdata;
        endcase
    end
endmodule
